// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: addresses, op encodings,
// mstatus field positions, the misa value, and the writable-bit masks.
package csr_pkg;

    localparam int CSR_XLEN = 32;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RW  = 2'b01,
        OP_RS  = 2'b10,
        OP_RC  = 2'b11
    } csr_op_e;

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MEDELEG   = 12'h302;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MSTATUS_MPP_LO = 11;

    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
    localparam logic [31:0] WMASK_MSTATUS = 32'h0000_0088;
    localparam logic [31:0] WMASK_MTVEC   = 32'hFFFF_FFFD;
    localparam logic [31:0] WMASK_MEPC    = 32'hFFFF_FFFC;
    localparam logic [31:0] WMASK_FULL    = 32'hFFFF_FFFF;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] wdata);
        case (op)
            OP_RW:   return wdata;
            OP_RS:   return old_val | wdata;
            OP_RC:   return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_m_counter64.sv
// 64-bit free-running counter with independently loadable halves; a load in
// either half suppresses that cycle's increment.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_count[31:0]  <= i_wdata;
            if (i_wr_hi) r_count[63:32] <= i_wdata;
        end else begin
            r_count <= r_count + 64'(i_inc);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/csr_file_m.sv
// Machine-mode CSR unit: atomic RW/RS/RC access with illegal detection,
// 64-bit mcycle/minstret, and trap entry / mret sequencing.
module csr_file_m
    import csr_pkg::*;
#(
    parameter int          XLEN          = 32,
    parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800,
    parameter logic [31:0] MEDELEG_RESET = 32'h0001_0000,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0170,
    parameter int          HART_ID       = 0,
    parameter int          COUNTERS_EN   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_csr_valid,
    input  logic [1:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_csr_illegal,
    input  logic            i_retire,
    input  logic            i_trap_valid,
    input  logic [XLEN-1:0] i_trap_cause,
    input  logic [XLEN-1:0] i_trap_pc,
    input  logic [XLEN-1:0] i_trap_tval,
    input  logic            i_mret,
    output logic [XLEN-1:0] o_trap_vector,
    output logic [XLEN-1:0] o_mepc_out,
    output logic            o_mie_bit
);

    localparam logic CNT_IMPL = (COUNTERS_EN != 0);

    logic            r_mie, r_mpie;
    logic [XLEN-1:0] r_medeleg, r_mie_csr, r_mtvec, r_mscratch;
    logic [XLEN-1:0] r_mepc, r_mcause, r_mtval;
    logic [63:0]     w_mcycle, w_minstret;
    logic [XLEN-1:0] w_old, w_new, w_base;
    logic            w_impl, w_write_attempt, w_illegal, w_wr;
    csr_op_e         w_op;

    assign w_op = csr_op_e'(i_csr_op);

    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (i_csr_addr)
            A_MSTATUS:   w_old = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            A_MISA:      w_old = MISA_VALUE;
            A_MEDELEG:   w_old = r_medeleg;
            A_MIE:       w_old = r_mie_csr;
            A_MTVEC:     w_old = r_mtvec;
            A_MSCRATCH:  w_old = r_mscratch;
            A_MEPC:      w_old = r_mepc;
            A_MCAUSE:    w_old = r_mcause;
            A_MTVAL:     w_old = r_mtval;
            A_MCYCLE,   A_CYCLE:    begin w_old = w_mcycle[31:0];    w_impl = CNT_IMPL; end
            A_MCYCLEH,  A_CYCLEH:   begin w_old = w_mcycle[63:32];   w_impl = CNT_IMPL; end
            A_MINSTRET, A_INSTRET:  begin w_old = w_minstret[31:0];  w_impl = CNT_IMPL; end
            A_MINSTRETH, A_INSTRETH: begin w_old = w_minstret[63:32]; w_impl = CNT_IMPL; end
            A_MHARTID:   w_old = XLEN'(HART_ID);
            default:     w_impl = 1'b0;
        endcase
    end

    // RS/RC with a zero operand is a pure read and may target read-only CSRs.
    assign w_write_attempt = (w_op == OP_RW) ||
                             (((w_op == OP_RS) || (w_op == OP_RC)) && (i_csr_wdata != '0));
    assign w_illegal = i_csr_valid && ((w_op == OP_NOP) || !w_impl ||
                                       (w_write_attempt && (i_csr_addr[11:10] == 2'b11)));
    assign w_wr      = i_csr_valid && !w_illegal && w_write_attempt;
    assign w_new     = csr_apply_op(w_op, w_old, i_csr_wdata);

    assign o_csr_illegal = w_illegal;
    assign o_csr_rdata   = (i_csr_valid && !w_illegal) ? w_old : '0;

    // Counter writes are never dropped by a concurrent trap or mret.
    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (1'b1),
        .i_wr_lo (w_wr && (i_csr_addr == A_MCYCLE)),
        .i_wr_hi (w_wr && (i_csr_addr == A_MCYCLEH)),
        .i_wdata (w_new),
        .o_count (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (i_retire),
        .i_wr_lo (w_wr && (i_csr_addr == A_MINSTRET)),
        .i_wr_hi (w_wr && (i_csr_addr == A_MINSTRETH)),
        .i_wdata (w_new),
        .o_count (w_minstret)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mie      <= MSTATUS_RESET[MSTATUS_MIE];
            r_mpie     <= MSTATUS_RESET[MSTATUS_MPIE];
            r_medeleg  <= MEDELEG_RESET;
            r_mie_csr  <= '0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else if (i_trap_valid) begin
            r_mepc   <= i_trap_pc & WMASK_MEPC;
            r_mcause <= i_trap_cause;
            r_mtval  <= i_trap_tval;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (i_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr) begin
            case (i_csr_addr)
                A_MSTATUS: begin
                    r_mie  <= w_new[MSTATUS_MIE];
                    r_mpie <= w_new[MSTATUS_MPIE];
                end
                A_MEDELEG:  r_medeleg  <= w_new & WMASK_FULL;
                A_MIE:      r_mie_csr  <= w_new & WMASK_FULL;
                A_MTVEC:    r_mtvec    <= w_new & WMASK_MTVEC;
                A_MSCRATCH: r_mscratch <= w_new & WMASK_FULL;
                A_MEPC:     r_mepc     <= w_new & WMASK_MEPC;
                A_MCAUSE:   r_mcause   <= w_new & WMASK_FULL;
                A_MTVAL:    r_mtval    <= w_new & WMASK_FULL;
                default: ;
            endcase
        end
    end

    assign w_base        = {r_mtvec[31:2], 2'b00};
    assign o_trap_vector = (r_mtvec[0] && i_trap_cause[31])
                         ? w_base + (XLEN'(i_trap_cause[30:0]) << 2)
                         : w_base;
    assign o_mepc_out    = r_mepc;
    assign o_mie_bit     = r_mie;

endmodule
